ram_dump_uart_tx: RTL and testbench
===================================

// Module: ram_dump_uart_tx
// PURPOSE
//  Parametrised RAM-readout engine: on a start pulse it reads word_count words of DATA_W bits
//  from a synchronous RAM port, beginning at base_addr, splits each word into bytes and sends
//  them as 8N1 UART frames. It sits between the CPU's end-of-program flag and the shared data
//  RAM port, and adds region selection, byte ordering, an optional sync header, abort and done.
// PARAMETERS
//  DATA_W        16   RAM word width; must be a multiple of 8 (BYTES = DATA_W/8)
//  ADDR_W        6    RAM address width
//  CLKS_PER_BIT  434  clk cycles per UART bit, >= 2 (50 MHz / 115200)
//  RAM_LAT       1    clk cycles from ram_rd_en to valid ram_data, 1..3
//  MSB_FIRST     1    1: send byte [DATA_W-1 -: 8] of each word first; 0: send byte [7:0] first
//  SYNC_EN       0    1: send SYNC_BYTE once before the first word of each dump
//  SYNC_BYTE     8'hA5 header value
// PORTS
//  clk          in   1         system clock; all logic rising-edge
//  reset        in   1         asynchronous assert, active-low; deassert synchronised externally
//  start        in   1         single-cycle request; sampled only in IDLE
//  abort        in   1         level; stops the dump at the next byte boundary
//  base_addr    in   ADDR_W    first word address; captured on an accepted start
//  word_count   in   ADDR_W+1  words to send, 0..2^ADDR_W; captured on an accepted start
//  ram_rd_en    out  1         RAM read strobe, one cycle per word
//  ram_addr     out  ADDR_W    RAM address, valid while ram_rd_en is high
//  ram_data     in   DATA_W    RAM read data, valid RAM_LAT cycles after ram_rd_en
//  uart_tx      out  1         serial line; idles high
//  busy         out  1         high from the cycle after an accepted start until done
//  done         out  1         one-cycle pulse at the end of the dump (normal or abort)
// BEHAVIOUR
//  - Reset values: uart_tx=1, busy=0, done=0, ram_rd_en=0, ram_addr=0. Reset mid-frame forces
//    uart_tx high at once; the partial frame is discarded.
//  - FSM: IDLE -> (SYNC if SYNC_EN) -> RD_REQ -> RD_WAIT (RAM_LAT cycles) -> SEND (BYTES
//    frames) -> RD_REQ for the next word or FIN -> IDLE. done is asserted in FIN; busy drops
//    in the same cycle.
//  - start is accepted only in IDLE with busy=0. start during busy is ignored.
//  - word_count=0: no RAM reads and no frames. done pulses 2 cycles after start.
//  - Address counter is ADDR_W bits and wraps modulo 2^ADDR_W, so base 62 with count 4 reads
//    addresses 62, 63, 0, 1. word_count=2^ADDR_W reads every location exactly once.
//  - ram_data is latched into a word shift register on the last RD_WAIT cycle. The next RAM
//    read is issued only after the last byte of the current word is loaded into the serialiser.
//  - Frame: start bit 0, data bits LSB-first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT
//    clocks. Frames are back-to-back with no idle gap; first start bit 1 cycle after the load.
//  - abort: sampled at each byte boundary (stop bit completed). If high, go to FIN and do not
//    send the remaining bytes or words. abort in IDLE has no effect. start together with abort
//    in IDLE is accepted; no bytes are sent and done follows.
//  - Total frames per dump = SYNC_EN + word_count*BYTES.
// STRUCTURE
//  - Shared package holds the FSM state encoding, the UART frame constants (START=0, STOP=1,
//    FRAME_BITS=10) and the default SYNC_BYTE.
//  - One sub-module, uart_tx_8n1 (#CLKS_PER_BIT):
//    in: clk, reset, load, byte_in[7:0]; out: tx, ready.
//  - The top holds the FSM, the address/word counters and the word shift register.
// TESTING (CLKS_PER_BIT=4, DATA_W=16, ADDR_W=6, RAM model preloaded mem[i]=16'h1100+i)
//  1 base=3, count=2, MSB_FIRST=1 -> bytes 11,03,11,04 on uart_tx; 2 ram_rd_en pulses at
//    addresses 3, 4; done once after the 4th stop bit; busy high the whole time.
//  2 count=0 -> ram_rd_en never high, uart_tx constant 1, done 2 cycles after start.
//  3 base=62, count=3, MSB_FIRST=0 -> addresses 62, 63, 0; bytes 3E,11,3F,11,00,11.
//  4 SYNC_EN=1, count=1 -> A5 then the word's bytes; every bit period exactly 4 clocks.
//  5 abort raised in the middle of byte 2 of a count=8 dump -> byte 2 finishes, no more frames,
//    done pulses; a second start during busy is ignored (no extra frames).
//  6 reset asserted in the middle of a frame -> uart_tx=1 and busy=0 at once; a new start after
//    release produces a clean dump.

Source files
------------

// File: rtl/ram_dump_uart_tx_pkg.sv
// Shared definitions for the RAM dump engine: FSM encoding, 8N1 frame constants
// and the default sync header value.
package ram_dump_uart_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_RD_REQ,
      S_RD_WAIT,
      S_SEND,
      S_FIN
   } state_t;

   localparam logic       UART_START        = 1'b0;
   localparam logic       UART_STOP         = 1'b1;
   localparam int         FRAME_BITS        = 10;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/ram_dump_uart_tx_uart.sv
// 8N1 UART serialiser. ready rises in the last clock of the stop bit so a load in
// that cycle starts the next frame with no idle gap.
module uart_tx_8n1
   import ram_dump_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] byte_in,
   output logic       tx,
   output logic       ready
);

   localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

   logic             active_q;
   logic [CNT_W-1:0] clk_cnt_q;
   logic [3:0]       bit_idx_q;
   logic [8:0]       shreg_q;
   logic             bit_end;

   assign bit_end = active_q && (clk_cnt_q == CNT_LAST);
   assign ready   = !active_q || (bit_end && (bit_idx_q == BIT_LAST));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_q  <= 1'b0;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         tx        <= UART_STOP;
      end else if (load && ready) begin
         active_q  <= 1'b1;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         tx        <= UART_START;
      end else if (bit_end) begin
         clk_cnt_q <= '0;
         if (bit_idx_q == BIT_LAST) begin
            active_q <= 1'b0;
            tx       <= UART_STOP;
         end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
            tx        <= shreg_q[0];
         end
      end else if (active_q) begin
         clk_cnt_q <= clk_cnt_q + 1'b1;
      end
   end

   // Data bits LSB-first, stop bit shifted in behind them.
   always_ff @(posedge clk) begin
      if (load && ready) begin
         shreg_q <= {UART_STOP, byte_in};
      end else if (bit_end) begin
         shreg_q <= {UART_STOP, shreg_q[8:1]};
      end
   end

endmodule

// File: rtl/ram_dump_uart_tx.sv
// RAM readout engine: reads a word region from a synchronous RAM port and streams
// its bytes over an 8N1 UART, with optional sync header, abort and done pulse.
module ram_dump_uart_tx
   import ram_dump_uart_tx_pkg::*;
#(
   parameter int         DATA_W       = 16,
   parameter int         ADDR_W       = 6,
   parameter int         CLKS_PER_BIT = 434,
   parameter int         RAM_LAT      = 1,
   parameter int         MSB_FIRST    = 1,
   parameter int         SYNC_EN      = 0,
   parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_data,
   output logic              uart_tx,
   output logic              busy,
   output logic              done
);

   localparam int              BYTES    = DATA_W / 8;
   localparam int              BI_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BI_W-1:0] BI_LAST  = BI_W'(BYTES - 1);
   localparam logic [1:0]      LAT_LAST = 2'(RAM_LAT - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     words_q;
   logic [DATA_W-1:0]   wsr_q;
   logic [BI_W-1:0]     byte_idx_q;
   logic [1:0]          lat_q;
   logic                tx_ready;
   logic                tx_load;
   logic [7:0]          tx_byte;
   logic [7:0]          cur_byte;
   logic                word_latch;
   logic                send_load;

   assign cur_byte   = (MSB_FIRST != 0) ? wsr_q[DATA_W-1 -: 8] : wsr_q[7:0];
   assign word_latch = (state_q == S_RD_WAIT) && (lat_q == LAT_LAST);
   assign send_load  = tx_load && (state_q == S_SEND);

   assign ram_addr = addr_q;
   assign done     = (state_q == S_FIN);
   assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // In RD_REQ the serialiser is only ready when idle at dump start or once the
   // final stop bit ends, so abort there never cuts a frame short.
   always_comb begin
      state_d   = state_q;
      tx_load   = 1'b0;
      tx_byte   = cur_byte;
      ram_rd_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (SYNC_EN != 0) ? S_SYNC : S_RD_REQ;
            end
         end
         S_SYNC: begin
            if (tx_ready) begin
               if (abort) begin
                  state_d = S_FIN;
               end else begin
                  tx_load = 1'b1;
                  tx_byte = SYNC_BYTE;
                  state_d = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: begin
            if (tx_ready && ((words_q == '0) || abort)) begin
               state_d = S_FIN;
            end else if (words_q != '0) begin
               ram_rd_en = 1'b1;
               state_d   = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (lat_q == LAT_LAST) begin
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (tx_ready) begin
               if (abort) begin
                  state_d = S_FIN;
               end else begin
                  tx_load = 1'b1;
                  if (byte_idx_q == BI_LAST) begin
                     state_d = S_RD_REQ;
                  end
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q     <= '0;
         words_q    <= '0;
         byte_idx_q <= '0;
         lat_q      <= '0;
      end else begin
         if ((state_q == S_IDLE) && start) begin
            addr_q  <= base_addr;
            words_q <= word_count;
         end
         if (ram_rd_en) begin
            addr_q  <= addr_q + 1'b1;
            words_q <= words_q - 1'b1;
            lat_q   <= '0;
         end else if (state_q == S_RD_WAIT) begin
            lat_q <= lat_q + 1'b1;
         end
         if (word_latch) begin
            byte_idx_q <= '0;
         end else if (send_load) begin
            byte_idx_q <= byte_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (word_latch) begin
         wsr_q <= ram_data;
      end else if (send_load) begin
         wsr_q <= (MSB_FIRST != 0) ? (wsr_q << 8) : (wsr_q >> 8);
      end
   end

   uart_tx_8n1 #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk    (clk),
      .reset  (reset),
      .load   (tx_load),
      .byte_in(tx_byte),
      .tx     (uart_tx),
      .ready  (tx_ready)
   );

endmodule

// File: tb/tb_ram_dump_uart_tx.sv
// Bench for ram_dump_uart_tx: three configurations share a RAM image; a UART
// decoder and an address watcher pop expectations from scoreboard queues.
module tb_ram_dump_uart_tx;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  base_addr;
   logic [6:0]  word_count;
   logic        abort;
   logic        start_a, start_b, start_c;
   logic        rd_en_a, rd_en_b, rd_en_c;
   logic [5:0]  addr_a, addr_b, addr_c;
   logic [15:0] rdata_a, rdata_b, rdata_c;
   logic        tx_a, tx_b, tx_c;
   logic        busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c;

   logic [1:0]  sel;
   logic        tx_s, busy_s, done_s, rd_en_s;
   logic [5:0]  addr_s;

   logic [15:0] mem [64];
   logic [7:0]  exp_q [$];
   logic [5:0]  exp_addr [$];
   int          vectors;
   int          miscompares;
   int          frames_seen;
   bit          allow_extra_reads;

   always #5 clk = ~clk;

   ram_dump_uart_tx #(.DATA_W(16), .ADDR_W(6), .CLKS_PER_BIT(CPB), .RAM_LAT(1),
                      .MSB_FIRST(1), .SYNC_EN(0)) u_a (
      .clk(clk), .reset(rst_n), .start(start_a), .abort(abort), .base_addr(base_addr),
      .word_count(word_count), .ram_rd_en(rd_en_a), .ram_addr(addr_a), .ram_data(rdata_a),
      .uart_tx(tx_a), .busy(busy_a), .done(done_a));

   ram_dump_uart_tx #(.DATA_W(16), .ADDR_W(6), .CLKS_PER_BIT(CPB), .RAM_LAT(1),
                      .MSB_FIRST(0), .SYNC_EN(0)) u_b (
      .clk(clk), .reset(rst_n), .start(start_b), .abort(abort), .base_addr(base_addr),
      .word_count(word_count), .ram_rd_en(rd_en_b), .ram_addr(addr_b), .ram_data(rdata_b),
      .uart_tx(tx_b), .busy(busy_b), .done(done_b));

   ram_dump_uart_tx #(.DATA_W(16), .ADDR_W(6), .CLKS_PER_BIT(CPB), .RAM_LAT(1),
                      .MSB_FIRST(1), .SYNC_EN(1)) u_c (
      .clk(clk), .reset(rst_n), .start(start_c), .abort(abort), .base_addr(base_addr),
      .word_count(word_count), .ram_rd_en(rd_en_c), .ram_addr(addr_c), .ram_data(rdata_c),
      .uart_tx(tx_c), .busy(busy_c), .done(done_c));

   // Synchronous RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (rd_en_a) rdata_a <= mem[addr_a];
      if (rd_en_b) rdata_b <= mem[addr_b];
      if (rd_en_c) rdata_c <= mem[addr_c];
   end

   always_comb begin
      tx_s    = tx_a;
      busy_s  = busy_a;
      done_s  = done_a;
      rd_en_s = rd_en_a;
      addr_s  = addr_a;
      case (sel)
         2'd1: begin
            tx_s = tx_b; busy_s = busy_b; done_s = done_b; rd_en_s = rd_en_b; addr_s = addr_b;
         end
         2'd2: begin
            tx_s = tx_c; busy_s = busy_c; done_s = done_c; rd_en_s = rd_en_c; addr_s = addr_c;
         end
         default: begin
         end
      endcase
   end

   // Decodes frames of the selected instance; every bit must hold for CPB clocks.
   task automatic uart_monitor();
      logic [9:0] fr;
      logic       stable;
      logic       dropped;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx_s === 1'b0) begin
            stable  = 1'b1;
            dropped = 1'b0;
            fr      = '0;
            for (int b = 0; b < 10; b++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (rst_n !== 1'b1) dropped = 1'b1;
                  if (c == 0) fr[b] = tx_s;
                  else if (tx_s !== fr[b]) stable = 1'b0;
               end
            end
            if (!dropped) begin
               frames_seen++;
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL uart_frame: got unexpected byte %02h, expected no frame", fr[8:1]);
               end else begin
                  e = exp_q.pop_front();
                  if (fr[8:1] !== e || fr[0] !== 1'b0 || fr[9] !== 1'b1 || !stable) begin
                     miscompares++;
                     $display("FAIL uart_frame: got byte %02h start %b stop %b stable %b, expected byte %02h start 0 stop 1 stable 1",
                              fr[8:1], fr[0], fr[9], stable, e);
                  end
               end
            end
         end
      end
   endtask

   task automatic addr_monitor();
      logic [5:0] ea;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && rd_en_s === 1'b1 && !allow_extra_reads) begin
            vectors++;
            if (exp_addr.size() == 0) begin
               miscompares++;
               $display("FAIL ram_read: got unexpected read at %0d, expected no read", addr_s);
            end else begin
               ea = exp_addr.pop_front();
               if (addr_s !== ea) begin
                  miscompares++;
                  $display("FAIL ram_read: got address %0d, expected %0d", addr_s, ea);
               end
            end
         end
      end
   endtask

   // Reference model: addresses wrap mod 64, mem[a] = 16'h1100 + a.
   task automatic expect_dump(input bit msb, input int base, input int cnt);
      logic [5:0]  a;
      logic [15:0] w;
      for (int i = 0; i < cnt; i++) begin
         a = 6'((base + i) % 64);
         w = 16'h1100 + {10'd0, a};
         exp_addr.push_back(a);
         if (msb) begin
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
         end else begin
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
         end
      end
   endtask

   task automatic pulse_start(input int k, input logic [5:0] base, input logic [6:0] cnt);
      base_addr  = base;
      word_count = cnt;
      @(negedge clk);
      case (k)
         1:       start_b = 1'b1;
         2:       start_c = 1'b1;
         default: start_a = 1'b1;
      endcase
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
   endtask

   task automatic run_to_done(input int limit, output bit got, output bit busy_ok);
      got     = 1'b0;
      busy_ok = 1'b1;
      for (int i = 0; i < limit; i++) begin
         if (done_s === 1'b1) begin
            got = 1'b1;
            break;
         end
         if (busy_s !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      vectors++;
      if ({tx_a, busy_a, done_a, rd_en_a, addr_a} !== {4'b1000, 6'd0}) begin
         miscompares++;
         $display("FAIL reset_a: got tx %b busy %b done %b rd %b addr %0d, expected 1 0 0 0 0",
                  tx_a, busy_a, done_a, rd_en_a, addr_a);
      end
      vectors++;
      if ({tx_b, busy_b, done_b, rd_en_b, addr_b} !== {4'b1000, 6'd0}) begin
         miscompares++;
         $display("FAIL reset_b: got tx %b busy %b done %b rd %b addr %0d, expected 1 0 0 0 0",
                  tx_b, busy_b, done_b, rd_en_b, addr_b);
      end
      vectors++;
      if ({tx_c, busy_c, done_c, rd_en_c, addr_c} !== {4'b1000, 6'd0}) begin
         miscompares++;
         $display("FAIL reset_c: got tx %b busy %b done %b rd %b addr %0d, expected 1 0 0 0 0",
                  tx_c, busy_c, done_c, rd_en_c, addr_c);
      end
   endtask

   task automatic test_basic();
      bit got, busy_ok;
      int f0;
      sel = 2'd0;
      expect_dump(1'b1, 3, 2);
      f0 = frames_seen;
      pulse_start(0, 6'd3, 7'd2);
      run_to_done(4000, got, busy_ok);
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL basic_done: got no done within 4000 cycles, expected a pulse");
      end
      vectors++;
      if (!busy_ok) begin
         miscompares++;
         $display("FAIL basic_busy: got busy low before done, expected high");
      end
      vectors++;
      if (busy_s !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_busy_at_done: got %b, expected 0", busy_s);
      end
      vectors++;
      if (frames_seen - f0 != 4 || exp_q.size() != 0 || exp_addr.size() != 0) begin
         miscompares++;
         $display("FAIL basic_count: got %0d frames, %0d bytes and %0d reads left, expected 4 0 0",
                  frames_seen - f0, exp_q.size(), exp_addr.size());
      end
      @(negedge clk);
      vectors++;
      if (done_s !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_done_width: got done %b one cycle later, expected 0", done_s);
      end
   endtask

   task automatic test_zero_count();
      bit tx_ok;
      sel = 2'd0;
      pulse_start(0, 6'd9, 7'd0);
      tx_ok = (tx_s === 1'b1);
      vectors++;
      if (done_s !== 1'b0 || busy_s !== 1'b1) begin
         miscompares++;
         $display("FAIL zero_cycle1: got done %b busy %b, expected 0 1", done_s, busy_s);
      end
      @(negedge clk);
      if (tx_s !== 1'b1) tx_ok = 1'b0;
      vectors++;
      if (done_s !== 1'b1 || busy_s !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_cycle2: got done %b busy %b, expected 1 0", done_s, busy_s);
      end
      repeat (20) begin
         @(negedge clk);
         if (tx_s !== 1'b1) tx_ok = 1'b0;
      end
      vectors++;
      if (!tx_ok) begin
         miscompares++;
         $display("FAIL zero_line: got uart_tx low, expected constant 1");
      end
   endtask

   task automatic test_wrap();
      bit got, busy_ok;
      int f0;
      sel = 2'd1;
      expect_dump(1'b0, 62, 3);
      f0 = frames_seen;
      pulse_start(1, 6'd62, 7'd3);
      run_to_done(4000, got, busy_ok);
      vectors++;
      if (!got || !busy_ok || frames_seen - f0 != 6 || exp_q.size() != 0 || exp_addr.size() != 0) begin
         miscompares++;
         $display("FAIL wrap: got done %b busy_ok %b frames %0d left %0d/%0d, expected 1 1 6 0/0",
                  got, busy_ok, frames_seen - f0, exp_q.size(), exp_addr.size());
      end
   endtask

   task automatic test_sync();
      bit got, busy_ok;
      int f0, low_len;
      sel = 2'd2;
      exp_q.push_back(8'hA5);
      expect_dump(1'b1, 5, 1);
      f0 = frames_seen;
      pulse_start(2, 6'd5, 7'd1);
      for (int i = 0; i < 10 && tx_s !== 1'b0; i++) @(negedge clk);
      low_len = 0;
      for (int i = 0; i < 20 && tx_s === 1'b0; i++) begin
         low_len++;
         @(negedge clk);
      end
      vectors++;
      if (low_len != CPB) begin
         miscompares++;
         $display("FAIL sync_start_bit_len: got %0d clocks, expected %0d", low_len, CPB);
      end
      run_to_done(4000, got, busy_ok);
      vectors++;
      if (!got || !busy_ok || frames_seen - f0 != 3 || exp_q.size() != 0 || exp_addr.size() != 0) begin
         miscompares++;
         $display("FAIL sync: got done %b busy_ok %b frames %0d left %0d/%0d, expected 1 1 3 0/0",
                  got, busy_ok, frames_seen - f0, exp_q.size(), exp_addr.size());
      end
   endtask

   task automatic test_full_sweep();
      bit got, busy_ok;
      int f0;
      sel = 2'd1;
      expect_dump(1'b0, 17, 64);
      f0 = frames_seen;
      pulse_start(1, 6'd17, 7'd64);
      run_to_done(8000, got, busy_ok);
      vectors++;
      if (!got || !busy_ok || frames_seen - f0 != 128 || exp_q.size() != 0 || exp_addr.size() != 0) begin
         miscompares++;
         $display("FAIL full_sweep: got done %b busy_ok %b frames %0d left %0d/%0d, expected 1 1 128 0/0",
                  got, busy_ok, frames_seen - f0, exp_q.size(), exp_addr.size());
      end
   endtask

   task automatic test_start_abort();
      bit got, busy_ok, idle_ok;
      int f0;
      sel     = 2'd0;
      abort   = 1'b1;
      idle_ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (busy_s !== 1'b0 || done_s !== 1'b0) idle_ok = 1'b0;
      end
      vectors++;
      if (!idle_ok) begin
         miscompares++;
         $display("FAIL abort_idle: got busy or done high, expected both 0");
      end
      allow_extra_reads = 1'b1;
      f0 = frames_seen;
      pulse_start(0, 6'd0, 7'd5);
      run_to_done(50, got, busy_ok);
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL start_abort_done: got no done within 50 cycles, expected a pulse");
      end
      abort = 1'b0;
      repeat (60) @(negedge clk);
      vectors++;
      if (frames_seen - f0 != 0 || busy_s !== 1'b0) begin
         miscompares++;
         $display("FAIL start_abort_frames: got %0d frames busy %b, expected 0 0", frames_seen - f0, busy_s);
      end
      allow_extra_reads = 1'b0;
   endtask

   task automatic test_abort();
      bit got, busy_ok;
      int f0;
      sel = 2'd0;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h00);
      exp_addr.push_back(6'd0);
      exp_addr.push_back(6'd1);
      f0 = frames_seen;
      pulse_start(0, 6'd0, 7'd8);
      for (int i = 0; i < 200 && frames_seen - f0 < 1; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      abort   = 1'b1;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      run_to_done(400, got, busy_ok);
      vectors++;
      if (!got || !busy_ok) begin
         miscompares++;
         $display("FAIL abort_done: got done %b busy_ok %b, expected 1 1", got, busy_ok);
      end
      @(negedge clk);
      abort = 1'b0;
      repeat (100) @(negedge clk);
      vectors++;
      if (frames_seen - f0 != 2 || exp_q.size() != 0 || busy_s !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_frames: got %0d frames, %0d bytes left, busy %b, expected 2 0 0",
                  frames_seen - f0, exp_q.size(), busy_s);
      end
   endtask

   task automatic test_reset_mid();
      bit got, busy_ok;
      int f0;
      sel = 2'd0;
      expect_dump(1'b1, 10, 2);
      pulse_start(0, 6'd10, 7'd2);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i >= 8 && tx_s === 1'b0) break;
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: got tx %b busy %b done %b, expected 1 0 0", tx_a, busy_a, done_a);
      end
      exp_q.delete();
      exp_addr.delete();
      repeat (50) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      expect_dump(1'b1, 7, 1);
      f0 = frames_seen;
      pulse_start(0, 6'd7, 7'd1);
      run_to_done(4000, got, busy_ok);
      vectors++;
      if (!got || !busy_ok || frames_seen - f0 != 2 || exp_q.size() != 0 || exp_addr.size() != 0) begin
         miscompares++;
         $display("FAIL reset_recover: got done %b busy_ok %b frames %0d left %0d/%0d, expected 1 1 2 0/0",
                  got, busy_ok, frames_seen - f0, exp_q.size(), exp_addr.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h1100 + 16'(i);
      rst_n             = 1'b0;
      start_a           = 1'b0;
      start_b           = 1'b0;
      start_c           = 1'b0;
      abort             = 1'b0;
      base_addr         = '0;
      word_count        = '0;
      sel               = 2'd0;
      vectors           = 0;
      miscompares       = 0;
      frames_seen       = 0;
      allow_extra_reads = 1'b0;
      fork
         uart_monitor();
         addr_monitor();
      join_none
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      test_basic();
      test_zero_count();
      test_wrap();
      test_sync();
      test_full_sweep();
      test_start_abort();
      test_abort();
      test_reset_mid();
      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
